// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : traffic_pkg
// Brief    : Shared state encoding, lamp codes and green-time saturation.
// Revision : 1.0
// ============================================================================
package traffic_pkg;

    typedef enum logic [2:0] {
        ST_INIT     = 3'd0,
        ST_GREEN    = 3'd1,
        ST_YELLOW   = 3'd2,
        ST_ALL_RED  = 3'd3,
        ST_PED_WALK = 3'd4,
        ST_PREEMPT  = 3'd5
    } state_t;

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    // Saturate to max_g and never return a zero-length green.
    function automatic int unsigned green_sat(input int unsigned raw, input int unsigned max_g);
        int unsigned v;
        v = (raw > max_g) ? max_g : raw;
        return (v == 0) ? 1 : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_phase_ctrl_prio_rr_sel.sv
`default_nettype none
// ============================================================================
// Module   : prio_rr_sel
// Brief    : Lowest-set-bit select and round-robin next-nonzero select.
// Revision : 1.0
// ============================================================================
module prio_rr_sel #(
    parameter int NUM_PHASES = 4,
    parameter int PH_W       = $clog2(NUM_PHASES)
) (
    input  logic [NUM_PHASES-1:0] i_req,
    input  logic [NUM_PHASES-1:0] i_nz,
    input  logic [PH_W-1:0]       i_base,
    output logic [PH_W-1:0]       o_lo_idx,
    output logic                  o_lo_any,
    output logic [PH_W-1:0]       o_rr_idx
);

    always_comb begin : b_lo
        o_lo_any = 1'b0;
        o_lo_idx = '0;
        for (int i = NUM_PHASES - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_lo_any = 1'b1;
                o_lo_idx = PH_W'(i);
            end
        end
    end

    // Search base+1 .. base+N; with nothing nonzero fall back to base+1.
    always_comb begin : b_rr
        logic found;
        int   j;
        found    = 1'b0;
        j        = 0;
        o_rr_idx = PH_W'((int'(i_base) + 1) % NUM_PHASES);
        for (int k = 1; k <= NUM_PHASES; k++) begin
            j = (int'(i_base) + k) % NUM_PHASES;
            if (!found && i_nz[j]) begin
                found    = 1'b1;
                o_rr_idx = PH_W'(j);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/traffic_phase_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : traffic_phase_ctrl
// Brief    : N-phase signal controller with ped walk and emergency pre-emption.
//            Define SKIP_EMPTY_EN to skip approaches with no queued vehicles.
// Revision : 1.0
// ============================================================================
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int NUM_PHASES  = 4,
    parameter int CNT_W       = 3,
    parameter int TIME_W      = 6,
    parameter int BASE_GREEN  = 10,
    parameter int GREEN_SHIFT = 1,
    parameter int MAX_GREEN   = 40,
    parameter int YELLOW_T    = 3,
    parameter int ALLRED_T    = 1,
    parameter int PED_T       = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sec_tick,
    input  logic [NUM_PHASES*CNT_W-1:0]   veh_cnt,
    input  logic                          ped_req,
    input  logic [NUM_PHASES-1:0]         emerg_req,
    output logic [NUM_PHASES*3-1:0]       light_ryg,
    output logic                          ped_walk,
    output logic [$clog2(NUM_PHASES)-1:0] cur_phase,
    output logic [TIME_W-1:0]             remain_time,
    output logic                          preempt_active
);

    localparam int              c_PH_W  = $clog2(NUM_PHASES);
    localparam logic [TIME_W-1:0] c_ONE   = TIME_W'(1);
    localparam logic [TIME_W-1:0] c_YEL_D = TIME_W'((YELLOW_T < 1) ? 1 : YELLOW_T);
    localparam logic [TIME_W-1:0] c_AR_D  = TIME_W'((ALLRED_T < 1) ? 1 : ALLRED_T);
    localparam logic [TIME_W-1:0] c_PED_D = TIME_W'((PED_T < 1) ? 1 : PED_T);

    state_t                  r_state, w_state_nx;
    logic [c_PH_W-1:0]       r_phase, w_phase_nx;
    logic [c_PH_W-1:0]       r_nxt_phase, w_nxt_phase_nx;
    logic                    r_ped_next, w_ped_next_nx;
    logic                    r_ped_latch, w_ped_latch_nx;
    logic                    r_preempt, w_preempt_nx;
    logic [TIME_W-1:0]       r_timer, w_timer_nx;
    logic [NUM_PHASES*3-1:0] r_light, w_light_nx;
    logic                    r_ped_walk;

    logic [c_PH_W-1:0]       w_gsel, w_emg_idx, w_rr_idx;
    logic                    w_emg_any, w_expire, w_wrap;
    logic [CNT_W-1:0]        w_cnt_sel;
    logic [TIME_W:0]         w_green_raw;
    logic [TIME_W-1:0]       w_green_d;
    logic [NUM_PHASES-1:0]   w_nz;

`ifdef SKIP_EMPTY_EN
    for (genvar gi = 0; gi < NUM_PHASES; gi++) begin : g_nz
        assign w_nz[gi] = |veh_cnt[gi*CNT_W +: CNT_W];
    end
`else
    // Every phase looks occupied, so the round-robin pick is plain rotation.
    assign w_nz = '1;
`endif

    prio_rr_sel #(
        .NUM_PHASES (NUM_PHASES),
        .PH_W       (c_PH_W)
    ) u_sel (
        .i_req    (emerg_req),
        .i_nz     (w_nz),
        .i_base   (r_phase),
        .o_lo_idx (w_emg_idx),
        .o_lo_any (w_emg_any),
        .o_rr_idx (w_rr_idx)
    );

    // Selected index at or below the current one means the search passed phase 0.
    assign w_wrap   = (w_rr_idx <= r_phase);
    assign w_expire = sec_tick && (r_timer <= c_ONE);

    always_comb begin
        w_gsel    = (r_state == ST_INIT) ? '0 : r_nxt_phase;
        w_cnt_sel = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            if (w_gsel == c_PH_W'(i)) w_cnt_sel = veh_cnt[i*CNT_W +: CNT_W];
        end
    end

    assign w_green_raw = (TIME_W+1)'(BASE_GREEN) + ((TIME_W+1)'(w_cnt_sel) << GREEN_SHIFT);
    assign w_green_d   = TIME_W'(green_sat(32'(w_green_raw), MAX_GREEN));

    always_comb begin
        w_state_nx     = r_state;
        w_phase_nx     = r_phase;
        w_timer_nx     = r_timer;
        w_preempt_nx   = r_preempt;
        w_nxt_phase_nx = r_nxt_phase;
        w_ped_next_nx  = r_ped_next;
        w_ped_latch_nx = r_ped_latch | ped_req;

        case (r_state)
            ST_INIT: begin
                w_state_nx   = ST_GREEN;
                w_phase_nx   = '0;
                w_timer_nx   = w_green_d;
                w_preempt_nx = 1'b0;
            end
            ST_GREEN: begin
                if (w_emg_any && (w_emg_idx == r_phase)) begin
                    w_timer_nx = r_timer;
                end else if (w_emg_any || w_expire) begin
                    w_state_nx   = ST_YELLOW;
                    w_timer_nx   = c_YEL_D;
                    w_preempt_nx = r_preempt | w_emg_any;
                end else if (sec_tick) begin
                    w_timer_nx = r_timer - c_ONE;
                end
            end
            ST_YELLOW: begin
                if (w_emg_any) w_preempt_nx = 1'b1;
                if (w_expire) begin
                    w_state_nx     = ST_ALL_RED;
                    w_timer_nx     = c_AR_D;
                    w_nxt_phase_nx = w_rr_idx;
                    w_ped_next_nx  = w_wrap & r_ped_latch;
                end else if (sec_tick) begin
                    w_timer_nx = r_timer - c_ONE;
                end
            end
            ST_ALL_RED: begin
                if (w_emg_any) w_preempt_nx = 1'b1;
                if (w_expire) begin
                    if (w_emg_any) begin
                        w_state_nx = ST_PREEMPT;
                        w_phase_nx = w_emg_idx;
                        w_timer_nx = '0;
                    end else if (r_ped_next) begin
                        w_state_nx     = ST_PED_WALK;
                        w_timer_nx     = c_PED_D;
                        w_ped_latch_nx = ped_req;
                        w_ped_next_nx  = 1'b0;
                        w_nxt_phase_nx = '0;
                    end else begin
                        w_state_nx   = ST_GREEN;
                        w_phase_nx   = r_nxt_phase;
                        w_timer_nx   = w_green_d;
                        w_preempt_nx = 1'b0;
                    end
                end else if (sec_tick) begin
                    w_timer_nx = r_timer - c_ONE;
                end
            end
            ST_PED_WALK: begin
                if (w_emg_any || w_expire) begin
                    w_state_nx   = ST_ALL_RED;
                    w_timer_nx   = c_AR_D;
                    w_preempt_nx = r_preempt | w_emg_any;
                end else if (sec_tick) begin
                    w_timer_nx = r_timer - c_ONE;
                end
            end
            ST_PREEMPT: begin
                w_timer_nx = '0;
                if (!w_emg_any || (w_emg_idx != r_phase)) begin
                    w_state_nx = ST_YELLOW;
                    w_timer_nx = c_YEL_D;
                end
            end
            default: begin
                w_state_nx = ST_INIT;
                w_timer_nx = '0;
            end
        endcase
    end

    // Lamps are computed from the next state so they register alongside it.
    always_comb begin
        for (int i = 0; i < NUM_PHASES; i++) begin
            w_light_nx[i*3 +: 3] = LAMP_R;
            if (w_phase_nx == c_PH_W'(i)) begin
                if (w_state_nx == ST_GREEN || w_state_nx == ST_PREEMPT)
                    w_light_nx[i*3 +: 3] = LAMP_G;
                else if (w_state_nx == ST_YELLOW)
                    w_light_nx[i*3 +: 3] = LAMP_Y;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_INIT;
            r_phase     <= '0;
            r_timer     <= '0;
            r_preempt   <= 1'b0;
            r_nxt_phase <= '0;
            r_ped_next  <= 1'b0;
            r_ped_latch <= 1'b0;
            r_light     <= {NUM_PHASES{LAMP_R}};
            r_ped_walk  <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_phase     <= w_phase_nx;
            r_timer     <= w_timer_nx;
            r_preempt   <= w_preempt_nx;
            r_nxt_phase <= w_nxt_phase_nx;
            r_ped_next  <= w_ped_next_nx;
            r_ped_latch <= w_ped_latch_nx;
            r_light     <= w_light_nx;
            r_ped_walk  <= (w_state_nx == ST_PED_WALK);
        end
    end

    assign light_ryg      = r_light;
    assign ped_walk       = r_ped_walk;
    assign cur_phase      = r_phase;
    assign remain_time    = r_timer;
    assign preempt_active = r_preempt;

endmodule
`default_nettype wire
